// File: rtl/game_pkg.sv
// Shared game-logic types and constants: game-over codes, sprite coordinate
// widths and the default round timing.
package game_pkg;

    typedef enum logic [1:0] {
        GO_NONE  = 2'b00,
        GO_TOM   = 2'b01,
        GO_JERRY = 2'b10
    } gameover_t;

    localparam int X_W = 11;
    localparam int Y_W = 10;

    localparam int DEF_FRAMES_PER_SEC = 60;
    localparam int DEF_GAME_TIME      = 99;
    localparam int DEF_HIT_DIST       = 32;
    localparam int DEF_CONFIRM_FRAMES = 2;
    localparam int DEF_CHEESE_GOAL    = 5;

endpackage

// File: rtl/gameover_gen_if.sv
// Game-over producer bus: per-frame game inputs towards the generator, and the
// game-over code plus round status back out of it.
interface gameover_gen_if;

    logic                        frame_tick;
    logic                        start;
    logic                        reset;
    logic [game_pkg::X_W-1:0]    tom_x;
    logic [game_pkg::Y_W-1:0]    tom_y;
    logic [game_pkg::X_W-1:0]    jerry_x;
    logic [game_pkg::Y_W-1:0]    jerry_y;
    logic [3:0]                  cheese_cnt;
    game_pkg::gameover_t         gameover;
    logic [6:0]                  time_left;
    logic                        playing;

    modport master (
        input  frame_tick, start, reset, tom_x, tom_y, jerry_x, jerry_y, cheese_cnt,
        output gameover, time_left, playing
    );

    modport slave (
        output frame_tick, start, reset, tom_x, tom_y, jerry_x, jerry_y, cheese_cnt,
        input  gameover, time_left, playing
    );

endinterface

// File: rtl/gameover_gen_round_timer.sv
// Round countdown: counts frame ticks into seconds and decrements time_left,
// saturating at zero; expire_pulse flags the tick that takes it to zero.
module round_timer #(
    parameter int FRAMES_PER_SEC = 60,
    parameter int GAME_TIME      = 99
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       en,
    input  logic       frame_tick,
    output logic [6:0] time_left,
    output logic       expire_pulse
);

   localparam int FC_W = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
   localparam logic [FC_W-1:0] FC_LAST = FC_W'(FRAMES_PER_SEC - 1);
   localparam logic [6:0]      T_INIT  = 7'(GAME_TIME);

   logic [FC_W-1:0] frame_cnt_reg;
   logic [6:0]      time_left_reg;
   logic            sec_wrap;

   assign sec_wrap     = en && frame_tick && (frame_cnt_reg == FC_LAST);
   // Combinational so the FSM can register the win on the same edge.
   assign expire_pulse = sec_wrap && (time_left_reg == 7'd1);
   assign time_left    = time_left_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         frame_cnt_reg <= '0;
         time_left_reg <= T_INIT;
      end else if (clear) begin
         frame_cnt_reg <= '0;
         time_left_reg <= T_INIT;
      end else if (en && frame_tick) begin
         if (sec_wrap) begin
            frame_cnt_reg <= '0;
            if (time_left_reg != 7'd0)
               time_left_reg <= time_left_reg - 7'd1;
         end else begin
            frame_cnt_reg <= frame_cnt_reg + FC_W'(1);
         end
      end
   end

endmodule

// File: rtl/gameover_gen.sv
// Game-over producer: runs a round, detects a confirmed Tom/Jerry collision or
// a Jerry win (cheese goal / time out) and latches the resulting code.
module gameover_gen
   import game_pkg::*;
#(
    parameter int FRAMES_PER_SEC = DEF_FRAMES_PER_SEC,
    parameter int GAME_TIME      = DEF_GAME_TIME,
    parameter int HIT_DIST       = DEF_HIT_DIST,
    parameter int CONFIRM_FRAMES = DEF_CONFIRM_FRAMES,
    parameter int CHEESE_GOAL    = DEF_CHEESE_GOAL
) (
    input  logic           clk,
    input  logic           rst,
    gameover_gen_if.master bus
);

   generate
      if (GAME_TIME < 1 || GAME_TIME > 127) begin : g_bad_time
         $error("gameover_gen: GAME_TIME must be 1..127");
      end
      if (CONFIRM_FRAMES < 1) begin : g_bad_confirm
         $error("gameover_gen: CONFIRM_FRAMES must be >= 1");
      end
      if (CHEESE_GOAL > 15) begin : g_bad_cheese
         $error("gameover_gen: CHEESE_GOAL must be <= 15");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, PLAY, CONFIRM, OVER} state_t;

   localparam int CW = $clog2(CONFIRM_FRAMES + 1);
   localparam logic [CW-1:0] CF_LAST = CW'(CONFIRM_FRAMES);
   localparam logic [11:0]   HIT_DX  = 12'(HIT_DIST);
   localparam logic [10:0]   HIT_DY  = 11'(HIT_DIST);
   localparam logic [3:0]    GOAL    = 4'(CHEESE_GOAL);

   state_t          state_reg, state_next;
   logic [CW-1:0]   hit_cnt_reg, hit_cnt_next;
   gameover_t       gameover_reg, gameover_next;
   logic            playing_reg, playing_next;
   logic [11:0]     dx;
   logic [10:0]     dy;
   logic            hit, catch_now, jerry_win, expire_pulse;
   logic            timer_clear, timer_en;

   always_comb begin
      dx = (bus.tom_x >= bus.jerry_x) ? ({1'b0, bus.tom_x} - {1'b0, bus.jerry_x})
                                      : ({1'b0, bus.jerry_x} - {1'b0, bus.tom_x});
      dy = (bus.tom_y >= bus.jerry_y) ? ({1'b0, bus.tom_y} - {1'b0, bus.jerry_y})
                                      : ({1'b0, bus.jerry_y} - {1'b0, bus.tom_y});
      hit = (dx < HIT_DX) && (dy < HIT_DY);
   end

   assign timer_clear = bus.reset || (state_reg == IDLE);
   assign timer_en    = (state_reg == PLAY) || (state_reg == CONFIRM);

   round_timer #(
      .FRAMES_PER_SEC(FRAMES_PER_SEC),
      .GAME_TIME     (GAME_TIME)
   ) u_round_timer (
      .clk         (clk),
      .rst         (rst),
      .clear       (timer_clear),
      .en          (timer_en),
      .frame_tick  (bus.frame_tick),
      .time_left   (bus.time_left),
      .expire_pulse(expire_pulse)
   );

   always_comb begin
      state_next    = state_reg;
      hit_cnt_next  = hit_cnt_reg;
      gameover_next = gameover_reg;
      catch_now     = 1'b0;
      jerry_win     = 1'b0;
      if (bus.reset) begin
         state_next    = IDLE;
         hit_cnt_next  = '0;
         gameover_next = GO_NONE;
      end else begin
         case (state_reg)
            IDLE: begin
               hit_cnt_next  = '0;
               gameover_next = GO_NONE;
               if (bus.start)
                  state_next = PLAY;
            end
            PLAY, CONFIRM: begin
               if (bus.frame_tick) begin
                  jerry_win = (bus.cheese_cnt >= GOAL) || expire_pulse;
                  if (!hit) begin
                     hit_cnt_next = '0;
                     state_next   = PLAY;
                  end else if (state_reg == PLAY) begin
                     hit_cnt_next = CW'(1);
                     if (CONFIRM_FRAMES == 1)
                        catch_now = 1'b1;
                     else
                        state_next = CONFIRM;
                  end else begin
                     hit_cnt_next = hit_cnt_reg + CW'(1);
                     if (hit_cnt_next == CF_LAST)
                        catch_now = 1'b1;
                  end
                  // A catch outranks a Jerry win decided on the same tick.
                  if (catch_now) begin
                     state_next    = OVER;
                     gameover_next = GO_TOM;
                  end else if (jerry_win) begin
                     state_next    = OVER;
                     gameover_next = GO_JERRY;
                  end
               end
            end
            default: ;
         endcase
      end
      playing_next = (state_next == PLAY) || (state_next == CONFIRM);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg    <= IDLE;
         hit_cnt_reg  <= '0;
         gameover_reg <= GO_NONE;
         playing_reg  <= 1'b0;
      end else begin
         state_reg    <= state_next;
         hit_cnt_reg  <= hit_cnt_next;
         gameover_reg <= gameover_next;
         playing_reg  <= playing_next;
      end
   end

   assign bus.gameover = gameover_reg;
   assign bus.playing  = playing_reg;

endmodule

// File: doc/gameover_gen.md
Name: gameover_gen

Overview:
- Producer side of the game-over interface.
- Watches Tom/Jerry positions, Jerry's cheese count and a round countdown, once per video frame.
- Emits the 2-bit `gameover` code consumed by the game-over latch and screen logic.
- Sits in the game-logic layer, between the sprite position controllers and the game-over/scoreboard path.
- Shares the user `reset` (restart) request with the latch, so both ends clear together.

Parameters:
- FRAMES_PER_SEC, 60, frame_tick pulses per countdown second
- GAME_TIME, 99, round length in seconds; must be ≤ 127
- HIT_DIST, 32, collision window in pixels, per axis, exclusive
- CONFIRM_FRAMES, 2, consecutive colliding frames required before a catch is declared; ≥ 1
- CHEESE_GOAL, 5, cheese count at which Jerry wins; ≤ 15

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- frame_tick  in  1  one-cycle pulse per frame (start of vblank)
- start  in  1  level; begins a round when idle
- reset  in  1  level; restart request, same signal fed to the game-over latch
- tom_x  in  11  Tom sprite x
- tom_y  in  10  Tom sprite y
- jerry_x  in  11  Jerry sprite x
- jerry_y  in  10  Jerry sprite y
- cheese_cnt  in  4  cheese collected by Jerry this round
- gameover  out  2  00 running/idle, 01 Tom caught Jerry, 10 Jerry won; 11 never driven
- time_left  out  7  remaining seconds
- playing  out  1  high while in PLAY or CONFIRM

Behaviour:
- All outputs are registered.
- Reset (rst low, asynchronous):
  - state = IDLE, gameover = 00, time_left = GAME_TIME, playing = 0.
  - Frame counter and hit counter = 0.
- `reset` input, synchronous:
  - Highest priority in every state, including OVER and mid-confirm.
  - Next cycle: same values as the asynchronous reset.
  - `start` is ignored while `reset` is high.
- IDLE:
  - `start` = 1 → PLAY next cycle.
  - Frame counter = 0, time_left = GAME_TIME.
- Sampling rules in PLAY/CONFIRM:
  - Inputs are evaluated only on frame_tick cycles.
  - Between ticks, state and counters hold.
- Collision test:
  - dx = |tom_x − jerry_x|, 12-bit unsigned.
  - dy = |tom_y − jerry_y|, 11-bit unsigned.
  - hit = (dx < HIT_DIST) and (dy < HIT_DIST).
  - Distance exactly HIT_DIST is not a hit.
- PLAY, on a tick with hit = 1:
  - hit_cnt = 1.
  - If CONFIRM_FRAMES = 1: catch immediately.
  - Otherwise → CONFIRM.
- CONFIRM, on each tick:
  - hit = 1: hit_cnt++; when hit_cnt reaches CONFIRM_FRAMES → catch.
  - hit = 0: hit_cnt = 0, → PLAY.
- Countdown, applies in both PLAY and CONFIRM:
  - On each tick the frame counter increments.
  - At FRAMES_PER_SEC−1 it wraps to 0 and time_left decrements.
  - time_left saturates at 0.
- Jerry win, evaluated on the same tick: cheese_cnt ≥ CHEESE_GOAL, or time_left transitions to 0.
- Same-tick priority: catch (01) > Jerry win (10). Only one code is ever issued.
- Latency:
  - gameover becomes non-zero exactly 1 clk after the deciding frame_tick edge.
  - State → OVER and playing = 0 at that same edge.
- OVER:
  - gameover, time_left and state are frozen until `reset`.
  - frame_tick, positions and `start` are ignored.
- GAME_TIME = 0 is illegal; elaborate-time assertion.

Decomposition:
- Shared package `game_pkg`:
  - `gameover_t` enum: GO_NONE = 2'b00, GO_TOM = 2'b01, GO_JERRY = 2'b10.
  - Screen width constants: X_W = 11, Y_W = 10.
  - Default timing constants.
- State enum is local to the module: IDLE, PLAY, CONFIRM, OVER.
- One natural sub-module: `round_timer`, holding the frame counter plus seconds countdown.
  - Ports: clk, rst, clear, en, frame_tick → time_left, expire_pulse.
  - Instantiated once.

Test Plan:
- Async rst low mid-CONFIRM → outputs 00 / 99 / 0 immediately, without waiting for a clk edge.
- start; Tom (100,100), Jerry (131,100), dx = 31; two ticks → gameover = 01 one clk after 2nd tick, playing = 0.
- Same but Jerry at (132,100), dx = 32 → no catch after 10 ticks. Also hit, miss, hit pattern → no catch (hit_cnt cleared on the miss).
- GAME_TIME = 2, FRAMES_PER_SEC = 3, no hit, cheese 0 → time_left 2 → 1 after 3 ticks, → 0 after 6 ticks, gameover = 10 at that edge.
- cheese_cnt = 5 on the same tick as the 2nd confirming hit → gameover = 01. Then `reset` pulse → 00 / 99, state IDLE; `start` held high during `reset` ignored.
- In OVER, 50 ticks with changing inputs → gameover and time_left stable. Deassert `reset`, assert `start` → new round, time_left = GAME_TIME.
